xmas_fair_sink: RTL and testbench
=================================

# xmas_fair_sink

Fair, self-checking sink for the xMAS request/response network. It sits directly downstream of the response merge (`merge2`) and replaces the plain sink on that channel. It consumes packets under an oracle-driven back-pressure pattern, but guarantees acceptance within a bounded number of stall cycles. It also counts requests and responses and flags handshake-protocol and illegal-type violations for the formal and simulation benches.

## Interface
Parameters:
- `CNT_W`, 16 — width of each transfer counter.
- `MAX_STALL`, 4 — maximum consecutive cycles a pending packet may be refused; legal range 1..15.

Ports:
- `clk`  in  1  — the single clock; all state updates on its rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `t`  in  64  — nondeterministic oracle; only `t[0]` is used, as the voluntary-accept request.
- `i0$irdy`  in  1  — upstream packet valid.
- `i0$trdy`  out  1  — sink ready.
- `i0$data$type`  in  2  — packet type: 0 = request, 1 = response, 2/3 = illegal.
- `cnt_req`  out  `CNT_W`  — accepted type-0 packets.
- `cnt_rsp`  out  `CNT_W`  — accepted type-1 packets.
- `err`  out  1  — sticky error flag.
- `err_code`  out  2  — first error seen: 0 none, 1 irdy dropped while pending, 2 data changed while pending, 3 illegal type accepted.

## Operation
- A transfer occurs in any cycle with `i0$irdy && i0$trdy`.
- `i0$trdy` = `!rst && (t[0] || state==FORCE)`.
  - It has no combinational dependence on `i0$irdy` or `i0$data$type`.
  - This prevents loops through the merge arbiter.
- The state machine uses a stall counter `stall` (4 bits).
- IDLE:
  - irdy && !trdy → PEND, with stall=1.
  - Otherwise stay in IDLE.
- PEND:
  - A transfer → IDLE, with stall=0.
  - !irdy → IDLE, with stall=0 (this is a protocol violation; see below).
  - Otherwise stall+1. When the next value equals `MAX_STALL`, → FORCE.
- FORCE:
  - trdy is forced to 1, so the pending packet transfers this cycle → IDLE, stall=0.
  - If irdy has dropped → IDLE.
- Fairness guarantee: a continuously offered packet is accepted no later than `MAX_STALL` cycles after it was first refused.
- Counters:
  - On a transfer, `cnt_req` increments if the type is 0; `cnt_rsp` increments if the type is 1.
  - Both saturate at all-ones and never wrap.
  - A transfer of type 2 or 3 increments neither counter and raises error 3.
- Errors:
  - The first error latches `err`=1 and `err_code`.
  - Both hold until `rst`; later errors are ignored.
  - If several errors occur in the same cycle, priority is 1 > 2 > 3.
- Protocol checks use `pend_q` (the previous cycle had irdy && !trdy) and `type_q` (the type in that cycle):
  - `pend_q && !irdy` → code 1.
  - `pend_q && irdy && type != type_q` → code 2.

## Timing
- Reset values: `i0$trdy`=0 while `rst` is high; `cnt_req`=`cnt_rsp`=0; `err`=0; `err_code`=0; state IDLE; stall=0; `pend_q`=0.
- Counters and error outputs are registered. They reflect a transfer or violation in cycle N from cycle N+1.
- Worst-case acceptance latency is `MAX_STALL` cycles after first refusal; the best case is 0 (same-cycle accept when `t[0]`=1).
- Reset mid-pending:
  - The pending state is discarded and `pend_q` is cleared.
  - No error is raised in the cycle after reset deassertion, even if irdy is then low.
- A transfer in the same cycle as the counter reaching saturation leaves the counter at all-ones.

## Configuration
- `XMAS_SINK_PERSIST_CHECK_EN`:
  - When defined, the `pend_q`/`type_q` registers and error codes 1 and 2 are compiled in.
  - When undefined, only the illegal-type check (code 3) exists. Codes 1 and 2 are never produced, and the fairness/counting behaviour is identical.

## Structure
- Shared package `xmas_pkg` holds:
  - type constants `TYPE_REQ`=0 and `TYPE_RSP`=1;
  - error-code constants `ERR_NONE`, `ERR_DROP`, `ERR_CHANGE`, `ERR_TYPE`;
  - the sink state enum (IDLE, PEND, FORCE).
- One sub-module, `xmas_persist_chk`:
  - inputs irdy, trdy and type;
  - outputs per-cycle drop/change pulses;
  - instantiated only under `XMAS_SINK_PERSIST_CHECK_EN`.
- The top module holds the FSM, counters and error latch.

## Test plan
- **Reset:** rst=1 for 2 cycles with irdy=1 → trdy=0, both counters 0, err=0; after release with `t[0]`=1 → first transfer counted next cycle.
- **Fairness:** irdy=1 type=0 held, `t[0]`=0 forever → trdy rises exactly 4 cycles after first refusal; `cnt_req`=1 one cycle later; err=0.
- **Mixed traffic:** `t[0]`=1, send types 0,1,1,0,1 back-to-back → `cnt_req`=2, `cnt_rsp`=3, err=0.
- **Illegal type:** transfer of type 2 → `err`=1, `err_code`=3, counters unchanged; a later drop violation leaves `err_code`=3.
- **Persistence (macro on):** refuse type 1, then next cycle present type 0 → `err_code`=2. Separately, refuse and then drop irdy → `err_code`=1. With the macro off, both sequences → err=0.
- **Saturation and reset mid-pending:** with `CNT_W`=4, send 17 responses → `cnt_rsp`=15. Separately, assert rst while in PEND → after release with irdy=0, err stays 0.

Source files
------------

// File: rtl/xmas_pkg.sv
// Shared xMAS sink definitions: packet type codes, error codes and sink FSM states.
package xmas_pkg;

  localparam logic [1:0] TYPE_REQ = 2'd0;
  localparam logic [1:0] TYPE_RSP = 2'd1;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_DROP   = 2'd1;
  localparam logic [1:0] ERR_CHANGE = 2'd2;
  localparam logic [1:0] ERR_TYPE   = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FORCE = 2'd2
  } sink_state_e;

endpackage

// File: rtl/xmas_persist_chk.sv
// Packet-persistence checker: a refused packet must stay valid with unchanged type
// on the next cycle. Emits single-cycle drop/change pulses.
module xmas_persist_chk
  import xmas_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       irdy,
  input  logic       trdy,
  input  logic [1:0] pkt_type,
  output logic       drop,
  output logic       change
);

  logic       pend_q;
  logic [1:0] type_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= 1'b0;
      type_q <= TYPE_REQ;
    end else begin
      pend_q <= irdy && !trdy;
      type_q <= pkt_type;
    end
  end

  assign drop   = pend_q && !irdy;
  assign change = pend_q && irdy && (pkt_type != type_q);

endmodule

// File: rtl/xmas_fair_sink.sv
// Fair self-checking xMAS sink: oracle back-pressure bounded by MAX_STALL, saturating
// request/response counters, sticky first-error latch. XMAS_SINK_PERSIST_CHECK_EN adds codes 1/2.
module xmas_fair_sink
  import xmas_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [63:0]      t,
  input  logic             i0_irdy,
  output logic             i0_trdy,
  input  logic [1:0]       i0_data_type,
  output logic [CNT_W-1:0] cnt_req,
  output logic [CNT_W-1:0] cnt_rsp,
  output logic             err,
  output logic [1:0]       err_code
);

  localparam logic [3:0]       STALL_MAX = 4'(MAX_STALL);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};

  sink_state_e state;
  logic [3:0]  stall;
  logic        irdy;
  logic        trdy;
  logic        xfer;
  logic [1:0]  pkt_type;
  logic        drop;
  logic        change;
  logic        illegal;
  logic        unused_t;

  assign irdy     = i0_irdy;
  assign pkt_type = i0_data_type;
  assign unused_t = ^t[63:1];

  // Ready depends only on reset, oracle and state so no loop forms through the merge.
  assign trdy    = !rst && (t[0] || state == FORCE);
  assign i0_trdy = trdy;
  assign xfer    = irdy && trdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      stall <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (irdy && !trdy) begin
            stall <= 4'd1;
            state <= (STALL_MAX == 4'd1) ? FORCE : PEND;
          end
        end
        PEND: begin
          if (xfer || !irdy) begin
            state <= IDLE;
            stall <= 4'd0;
          end else begin
            stall <= stall + 4'd1;
            if (stall + 4'd1 == STALL_MAX) state <= FORCE;
          end
        end
        FORCE: begin
          state <= IDLE;
          stall <= 4'd0;
        end
        default: begin
          state <= IDLE;
          stall <= 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_req <= '0;
      cnt_rsp <= '0;
    end else if (xfer) begin
      if (pkt_type == TYPE_REQ && cnt_req != CNT_SAT) cnt_req <= cnt_req + CNT_ONE;
      if (pkt_type == TYPE_RSP && cnt_rsp != CNT_SAT) cnt_rsp <= cnt_rsp + CNT_ONE;
    end
  end

`ifdef XMAS_SINK_PERSIST_CHECK_EN
  xmas_persist_chk u_persist_chk (
    .clk      (clk),
    .rst      (rst),
    .irdy     (irdy),
    .trdy     (trdy),
    .pkt_type (pkt_type),
    .drop     (drop),
    .change   (change)
  );
`else
  assign drop   = 1'b0;
  assign change = 1'b0;
`endif

  assign illegal = xfer && pkt_type[1];

  // Only the first error is kept; same-cycle ties resolve drop > change > type.
  always_ff @(posedge clk) begin
    if (rst) begin
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else if (!err && (drop || change || illegal)) begin
      err      <= 1'b1;
      err_code <= drop ? ERR_DROP : (change ? ERR_CHANGE : ERR_TYPE);
    end
  end

endmodule

// File: tb/tb_xmas_fair_sink.sv
// Directed bench for xmas_fair_sink: default instance plus a CNT_W=4 instance for saturation.
module tb_xmas_fair_sink;
  import xmas_pkg::*;

`ifdef XMAS_SINK_PERSIST_CHECK_EN
  localparam bit PERSIST = 1'b1;
`else
  localparam bit PERSIST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] t;
  logic        irdy;
  logic [1:0]  ptype;
  logic        trdy, trdy_s;
  logic [15:0] cnt_req, cnt_rsp;
  logic [3:0]  cnt_req_s, cnt_rsp_s;
  logic        err, err_s;
  logic [1:0]  err_code, err_code_s;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  xmas_fair_sink dut (
    .clk          (clk),
    .rst          (rst),
    .t            (t),
    .i0_irdy      (irdy),
    .i0_trdy      (trdy),
    .i0_data_type (ptype),
    .cnt_req      (cnt_req),
    .cnt_rsp      (cnt_rsp),
    .err          (err),
    .err_code     (err_code)
  );

  xmas_fair_sink #(.CNT_W(4), .MAX_STALL(4)) dut_s (
    .clk          (clk),
    .rst          (rst),
    .t            (t),
    .i0_irdy      (irdy),
    .i0_trdy      (trdy_s),
    .i0_data_type (ptype),
    .cnt_req      (cnt_req_s),
    .cnt_rsp      (cnt_rsp_s),
    .err          (err_s),
    .err_code     (err_code_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic drive(input logic t0, input logic v, input logic [1:0] ty);
    t     = {$urandom, $urandom};
    t[0]  = t0;
    irdy  = v;
    ptype = ty;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b1, 1'b0, 2'd0);
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] mix [5];
    mix = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd1};

    // Reset with a packet offered and the oracle willing
    rst = 1'b1;
    drive(1'b1, 1'b1, 2'd0);
    step();
    #1 chk("rst_trdy", 32'(trdy), 0);
    step();
    chk("rst_cnt_req", 32'(cnt_req), 0);
    chk("rst_cnt_rsp", 32'(cnt_rsp), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_err_code", 32'(err_code), 0);
    rst = 1'b0;
    drive(1'b1, 1'b1, 2'd0);
    #1 chk("post_rst_trdy", 32'(trdy), 1);
    step();
    chk("post_rst_cnt_req", 32'(cnt_req), 1);
    chk("post_rst_cnt_rsp", 32'(cnt_rsp), 0);
    drive(1'b0, 1'b0, 2'd0);

    // Fairness: oracle never accepts, FSM must force acceptance 4 cycles after refusal
    do_reset();
    drive(1'b0, 1'b1, 2'd0);
    for (int k = 0; k < 4; k++) begin
      #1 chk("fair_refused", 32'(trdy), 0);
      step();
    end
    #1 chk("fair_forced", 32'(trdy), 1);
    chk("fair_cnt_before", 32'(cnt_req), 0);
    step();
    drive(1'b0, 1'b0, 2'd0);
    chk("fair_cnt_after", 32'(cnt_req), 1);
    chk("fair_err", 32'(err), 0);
    #1 chk("fair_idle_trdy", 32'(trdy), 0);

    // Mixed traffic back-to-back
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b1, mix[k]);
      step();
    end
    drive(1'b0, 1'b0, 2'd0);
    chk("mix_cnt_req", 32'(cnt_req), 2);
    chk("mix_cnt_rsp", 32'(cnt_rsp), 3);
    chk("mix_err", 32'(err), 0);

    // Illegal type, then a later drop that must not overwrite the code
    do_reset();
    drive(1'b1, 1'b1, 2'd2);
    step();
    drive(1'b0, 1'b0, 2'd0);
    chk("ill_err", 32'(err), 1);
    chk("ill_code", 32'(err_code), 3);
    chk("ill_cnt_req", 32'(cnt_req), 0);
    chk("ill_cnt_rsp", 32'(cnt_rsp), 0);
    drive(1'b0, 1'b1, 2'd0);
    step();
    drive(1'b0, 1'b0, 2'd0);
    step();
    step();
    chk("ill_sticky_code", 32'(err_code), 3);
    chk("ill_sticky_err", 32'(err), 1);

    // Type changed while pending
    do_reset();
    drive(1'b0, 1'b1, 2'd1);
    step();
    drive(1'b0, 1'b1, 2'd0);
    step();
    drive(1'b0, 1'b0, 2'd0);
    chk("chg_err", 32'(err), 32'(PERSIST));
    chk("chg_code", 32'(err_code), PERSIST ? 32'd2 : 32'd0);
    step();
    chk("chg_sticky_code", 32'(err_code), PERSIST ? 32'd2 : 32'd0);

    // irdy dropped while pending
    do_reset();
    drive(1'b0, 1'b1, 2'd0);
    step();
    drive(1'b0, 1'b0, 2'd0);
    step();
    chk("drop_err", 32'(err), 32'(PERSIST));
    chk("drop_code", 32'(err_code), PERSIST ? 32'd1 : 32'd0);

    // Change and illegal type in the same cycle: change wins when checked
    do_reset();
    drive(1'b0, 1'b1, 2'd0);
    step();
    drive(1'b1, 1'b1, 2'd2);
    step();
    drive(1'b0, 1'b0, 2'd0);
    chk("prio_err", 32'(err), 1);
    chk("prio_code", 32'(err_code), PERSIST ? 32'd2 : 32'd3);
    chk("prio_cnt_req", 32'(cnt_req), 0);

    // Saturation on the 4-bit instance
    do_reset();
    for (int k = 0; k < 17; k++) begin
      drive(1'b1, 1'b1, 2'd1);
      step();
    end
    drive(1'b0, 1'b0, 2'd0);
    chk("sat_cnt_rsp_s", 32'(cnt_rsp_s), 15);
    chk("sat_cnt_req_s", 32'(cnt_req_s), 0);
    chk("sat_cnt_rsp", 32'(cnt_rsp), 17);
    chk("sat_err_s", 32'(err_s), 0);

    // Reset while pending, then release with irdy low
    do_reset();
    drive(1'b0, 1'b1, 2'd0);
    step();
    step();
    rst = 1'b1;
    drive(1'b1, 1'b1, 2'd0);
    #1 chk("midrst_trdy", 32'(trdy), 0);
    step();
    rst = 1'b0;
    drive(1'b0, 1'b0, 2'd0);
    step();
    step();
    chk("midrst_err", 32'(err), 0);
    chk("midrst_code", 32'(err_code), 0);
    drive(1'b0, 1'b1, 2'd0);
    for (int k = 0; k < 4; k++) begin
      #1 chk("midrst_refused", 32'(trdy), 0);
      step();
    end
    #1 chk("midrst_forced", 32'(trdy), 1);
    step();
    drive(1'b0, 1'b0, 2'd0);
    chk("midrst_cnt_req", 32'(cnt_req), 1);
    chk("midrst_err_end", 32'(err), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
